calc_arbiter: RTL

Sequencer and round-robin arbiter that shares one combinational sign-magnitude `calculator` instance between two requesters, such as the switch/button panel and a serial command port. It arbitrates between the two requesters, registers the winning operands, and holds them stable on the calculator inputs for a fixed settle window. It then captures the result and returns it to the winning requester over a valid/ready handshake. Divide-by-zero requests are optionally trapped without using the datapath.

---
 rtl/calc_arbiter_pkg.sv | 25 ++
 rtl/calc_arbiter_if.sv | 24 ++
 rtl/calc_arbiter_rr_arbiter2.sv | 17 +
 rtl/calc_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/calc_arbiter_pkg.sv
// Shared types for the calculator arbiter: operand/result widths, mode codes,
// FSM state encoding and the latched-operand record.
package calc_pkg;
  localparam int OPW  = 4;
  localparam int RESW = 8;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_MUL = 2'b10;
  localparam logic [1:0] MODE_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } calc_arb_state_t;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic           sign_a;
    logic           sign_b;
    logic [1:0]     mode;
  } calc_op_t;
endpackage

// File: rtl/calc_arbiter_if.sv
// Two-requester request/response bundle; master = requester side, slave = arbiter.
interface calc_arbiter_if;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [1:0] req_sign_a;
  logic [1:0] req_sign_b;
  logic [3:0] req_mode;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_sign;
  logic       rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_sign_a, req_sign_b, req_mode, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_sign, rsp_err
  );
  modport slave (
    input  req_valid, req_a, req_b, req_sign_a, req_sign_b, req_mode, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_sign, rsp_err
  );
endinterface

// File: rtl/calc_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, contention goes to the
// requester that did not win last time.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end
endmodule

// File: rtl/calc_arbiter.sv
// Shares one combinational calculator between two requesters.
// Optional CALC_ARB_DIVZERO_EN traps divide-by-zero at acceptance.
module calc_arbiter
    import calc_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    calc_arbiter_if.slave   bus,
    output logic [OPW-1:0]  calc_a,
    output logic [OPW-1:0]  calc_b,
    output logic            calc_sign_a,
    output logic            calc_sign_b,
    output logic [1:0]      calc_mode,
    input  logic [RESW-1:0] calc_result,
    input  logic            calc_result_sign
);
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    calc_arb_state_t state, nxt;
    logic [1:0]      gnt;
    logic            g_idx, accept, div0;
    logic            last_grant, owner;
    logic [3:0]      cnt;
    calc_op_t        op_q, req_op;
    logic [RESW-1:0] res_q;
    logic            sgn_q;

    rr_arbiter2 u_rr (.req(bus.req_valid), .last_grant(last_grant), .gnt(gnt));

    assign g_idx  = gnt[1];
    assign accept = (state == IDLE) && (|gnt);

    always_comb begin
        req_op        = '0;
        req_op.a      = g_idx ? bus.req_a[7:4] : bus.req_a[3:0];
        req_op.b      = g_idx ? bus.req_b[7:4] : bus.req_b[3:0];
        req_op.sign_a = bus.req_sign_a[g_idx];
        req_op.sign_b = bus.req_sign_b[g_idx];
        req_op.mode   = g_idx ? bus.req_mode[3:2] : bus.req_mode[1:0];
    end

`ifdef CALC_ARB_DIVZERO_EN
    logic err_q;
    assign div0 = (req_op.mode == MODE_DIV) && (req_op.b == '0);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)      err_q <= 1'b0;
        else if (accept) err_q <= div0;

    assign bus.rsp_err = err_q;
`else
    assign div0        = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (accept) nxt = div0 ? RESP : ISSUE;
            ISSUE:   if (cnt == '0) nxt = RESP;
            RESP:    if (bus.rsp_ready[owner]) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Counter counts SETTLE_CYCLES down to 0 before the capture cycle, so the
    // operands sit on the calculator for SETTLE_CYCLES+1 cycles before sampling.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            op_q       <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            res_q      <= '0;
            sgn_q      <= 1'b0;
        end else if (accept) begin
            op_q       <= req_op;
            owner      <= g_idx;
            last_grant <= g_idx;
            cnt        <= SETTLE_LD;
            if (div0) begin
                res_q <= '0;
                sgn_q <= 1'b0;
            end
        end else if (state == ISSUE) begin
            if (cnt == '0) begin
                res_q <= calc_result;
                sgn_q <= calc_result_sign & (|calc_result);
            end else begin
                cnt <= cnt - 4'd1;
            end
        end

    // rst_n gating keeps req_ready at 0 while reset is held even if requests are pending.
    assign bus.req_ready  = (rst_n && state == IDLE) ? gnt : 2'b00;
    assign bus.rsp_valid  = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_result = res_q;
    assign bus.rsp_sign   = sgn_q;

    assign calc_a      = op_q.a;
    assign calc_b      = op_q.b;
    assign calc_sign_a = op_q.sign_a;
    assign calc_sign_b = op_q.sign_b;
    assign calc_mode   = op_q.mode;
endmodule
